rca4: RTL and testbench
=======================

RCA4 -- requirements
Module: rca4

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a  input  4  addend A, unsigned or two's complement.
REQ-006 b  input  4  addend B, unsigned or two's complement.
REQ-007 cin  input  1  carry-in to bit 0.
REQ-008 in_valid  input  1  when 1, a, b and cin are sampled at the next rising clk edge.
REQ-009 s  output  4  registered sum bits [3:0].
REQ-010 cout  output  1  registered carry-out of bit 3.
REQ-011 ovf  output  1  registered signed overflow flag.
REQ-012 zero  output  1  registered flag, 1 when s == 0.
REQ-013 out_valid  output  1  registered; 1 for exactly the cycle after each accepted operation.

Function
REQ-014 The adder SHALL be a structural ripple chain of four 1-bit full-adder instances.
- Stage i: sum = a[i]^b[i]^c[i].
- Stage i: carry c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
- c[0] = cin; cout = c[4].
- No carry-lookahead or behavioural "+" in the datapath.
REQ-015 The full 5-bit result {cout, s} SHALL equal a + b + cin, computed modulo 32.
- Full range applies: max 15+15+1 = 31 gives cout=1, s=15.
REQ-016 ovf SHALL equal c[4] XOR c[3], i.e. two's-complement overflow of the 4-bit sum.
REQ-017 zero SHALL be 1 exactly when the registered s equals 4'b0000, regardless of cout.
REQ-018 Latency SHALL be one clock cycle.
- On a rising edge with rst=0 and in_valid=1: s, cout, ovf and zero load the result of the a, b, cin present before that edge.
- out_valid becomes 1 after the same edge.
REQ-019 On a rising edge with rst=0 and in_valid=0:
- s, cout, ovf and zero SHALL hold their previous values.
- out_valid SHALL become 0.
REQ-020 Back-to-back operations SHALL be supported: in_valid held at 1 gives a new result and out_valid=1 every cycle.
REQ-021 Outputs SHALL change only at rising clk edges; input changes between edges SHALL NOT affect the outputs.
REQ-022 No X propagation from the datapath: with known inputs, every output SHALL be 0 or 1 from the first edge after reset.

Reset
REQ-023 On a rising edge with rst=1, the block SHALL set s=0, cout=0, ovf=0, zero=0 and out_valid=0.
REQ-024 rst SHALL take priority over in_valid: an operation presented on the same edge as rst=1 is discarded.
REQ-025 Outputs are undefined before the first reset edge; the bench SHALL apply rst for at least one edge before checking.

Verification
REQ-026 The bench SHALL apply a=15, b=15, cin=0, in_valid=1 for one edge and require, after that edge:
- s=14, cout=1, ovf=0, zero=0, out_valid=1.
REQ-027 The bench SHALL apply a=15, b=0, cin=1 and require s=0, cout=1, zero=1, ovf=0.
REQ-028 The bench SHALL apply a=7, b=1, cin=0 and require s=8, cout=0, ovf=1, zero=0.
REQ-029 The bench SHALL perform an operation, then hold in_valid=0 while changing a to 3 for 3 edges, and require:
- s, cout, ovf and zero unchanged over those edges.
- out_valid=0 over those edges.
REQ-030 The bench SHALL assert rst=1 with in_valid=1, a=5, b=5 on the same edge and require all outputs 0 after that edge.
REQ-031 The bench SHALL run an exhaustive sweep of all 512 combinations of a, b and cin with in_valid=1 back-to-back and require:
- {cout, s} == a+b+cin one cycle later in every case.
- ovf and zero per REQ-016 and REQ-017 in every case.

Source files
------------

// File: rtl/rca4.sv
// 4-bit ripple-carry adder built from four full-adder cells, with registered
// sum, carry-out, signed overflow and zero flags plus a one-cycle valid strobe.

module rca4_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module rca4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       in_valid,
    output logic [3:0] s,
    output logic       cout,
    output logic       ovf,
    output logic       zero,
    output logic       out_valid
);
    // Stage p0: combinational ripple chain on the raw operands
    logic [4:0] c_p0;
    logic [3:0] sum_p0;
    logic       ovf_p0;
    logic       zero_p0;

    assign c_p0[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        rca4_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_p0[i]),
            .s  (sum_p0[i]),
            .co (c_p0[i+1])
        );
    end

    // Overflow is the disagreement between the carries into and out of the sign bit
    assign ovf_p0  = c_p0[4] ^ c_p0[3];
    assign zero_p0 = ~|sum_p0;

    // Stage p1: result registers; data holds while no operation is accepted
    logic [3:0] s_p1;
    logic       cout_p1;
    logic       ovf_p1;
    logic       zero_p1;
    logic       vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1    <= 4'b0000;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s_p1    <= sum_p0;
                cout_p1 <= c_p0[4];
                ovf_p1  <= ovf_p0;
                zero_p1 <= zero_p0;
            end
        end
    end

    assign s         = s_p1;
    assign cout      = cout_p1;
    assign ovf       = ovf_p1;
    assign zero      = zero_p1;
    assign out_valid = vld_p1;
endmodule

// File: tb/tb_rca4.sv
// Directed and exhaustive checks of the registered 4-bit ripple-carry adder.

module tb_rca4;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       out_valid;

    int total;
    int bad;

    rca4 dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_s;
        logic       exp_cout;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ez, input logic ev);
        chk({tag, ".s"},         {4'b0, s},         {4'b0, es});
        chk({tag, ".cout"},      {7'b0, cout},      {7'b0, ec});
        chk({tag, ".ovf"},       {7'b0, ovf},       {7'b0, eo});
        chk({tag, ".zero"},      {7'b0, zero},      {7'b0, ez});
        chk({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, ev});
    endtask

    initial begin
        logic [4:0] full;
        logic       m_ovf;

        total = 0;
        bad   = 0;

        //            a      b      cin   s      cout  ovf   zero
        vecs[0] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
        vecs[6] = '{4'd5,  4'd3,  1'b1, 4'd9,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'd12, 4'd2,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
        step();
        step();
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout,
                    vecs[i].exp_ovf, vecs[i].exp_zero, 1'b1);
        end

        // Hold: result 9+2=11 must persist while in_valid is low
        a = 4'd9; b = 4'd2; cin = 1'b0; in_valid = 1'b1;
        step();
        chk_all("hold_load", 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        a = 4'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("hold%0d", k), 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Inputs changing between edges must not reach the outputs
        a = 4'd6; b = 4'd6; cin = 1'b1; in_valid = 1'b1;
        #2;
        chk_all("midcycle", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("midcycle_load", 4'd13, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset wins over an operation presented on the same edge
        rst = 1'b1; a = 4'd5; b = 4'd5; cin = 1'b0; in_valid = 1'b1;
        step();
        chk_all("rst_prio", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Exhaustive back-to-back sweep against an arithmetic model
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a   = i[3:0];
            b   = i[7:4];
            cin = i[8];
            full  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            m_ovf = (a[3] == b[3]) && (full[3] != a[3]);
            step();
            chk($sformatf("sweep%0d.sum", i), {3'b0, cout, s}, {3'b0, full});
            chk($sformatf("sweep%0d.ovf", i), {7'b0, ovf}, {7'b0, m_ovf});
            chk($sformatf("sweep%0d.zero", i), {7'b0, zero}, {7'b0, (full[3:0] == 4'd0)});
            chk($sformatf("sweep%0d.vld", i), {7'b0, out_valid}, 8'd1);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_end.vld", {7'b0, out_valid}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
